// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_seq
// Brief    : Multi-cycle sequencer for single-precision add/sub. Latches
//            operands, resolves IEEE-754 special cases, holds the external
//            combinational adder inputs for LATENCY cycles, then captures and
//            saturates the sum.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_seq #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_sub,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] fadd_a,
    output logic [31:0] fadd_b,
    input  logic [31:0] fadd_result,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        invalid,
    output logic        overflow
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_check = 2'd1;
    localparam logic [1:0]  c_st_exec  = 2'd2;
    localparam logic [1:0]  c_st_done  = 2'd3;
    localparam logic [3:0]  c_last_cnt = 4'(LATENCY - 1);
    localparam logic [31:0] c_qnan     = 32'h7FC0_0000;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic        r_invalid;
    logic        r_overflow;

    logic        w_accept;
    logic        w_capture;
    logic        w_special;
    logic [31:0] w_spec_result;
    logic        w_spec_invalid;

    // Operand classification; exponent zero is treated as zero (denormal flush)
    logic w_a_max, w_b_max, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    assign w_a_max  = (r_a[30:23] == 8'hFF);
    assign w_b_max  = (r_b[30:23] == 8'hFF);
    assign w_a_nan  = w_a_max && (r_a[22:0] != 23'd0);
    assign w_b_nan  = w_b_max && (r_b[22:0] != 23'd0);
    assign w_a_inf  = w_a_max && (r_a[22:0] == 23'd0);
    assign w_b_inf  = w_b_max && (r_b[22:0] == 23'd0);
    assign w_a_zero = (r_a[30:23] == 8'h00);
    assign w_b_zero = (r_b[30:23] == 8'h00);

    assign w_accept  = (r_state == c_st_idle) && start;
    assign w_capture = (r_state == c_st_exec) && (r_cnt == c_last_cnt);

    always_comb begin
        w_special      = 1'b1;
        w_spec_result  = 32'd0;
        w_spec_invalid = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[31] != r_b[31]))) begin
            w_spec_result  = c_qnan;
            w_spec_invalid = 1'b1;
        end else if (w_a_inf) begin
            w_spec_result = r_a;
        end else if (w_b_inf) begin
            w_spec_result = r_b;
        end else if (w_a_zero && w_b_zero) begin
            w_spec_result = {r_a[31] & r_b[31], 31'd0};
        end else if (w_a_zero) begin
            w_spec_result = r_b;
        end else if (w_b_zero) begin
            w_spec_result = r_a;
        end else if ((r_a[30:0] == r_b[30:0]) && (r_a[31] != r_b[31])) begin
            w_spec_result = 32'd0;
        end else begin
            w_special = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (start) w_next_state = c_st_check;
            c_st_check: w_next_state = w_special ? c_st_done : c_st_exec;
            c_st_exec:  if (r_cnt == c_last_cnt) w_next_state = c_st_done;
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_result   <= 32'd0;
            r_invalid  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == c_st_exec && r_cnt != c_last_cnt) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end

            if (w_accept) begin
                r_a        <= op_a;
                r_b        <= {op_b[31] ^ op_sub, op_b[30:0]};
                r_invalid  <= 1'b0;
                r_overflow <= 1'b0;
            end

            if (r_state == c_st_check && w_special) begin
                r_result  <= w_spec_result;
                r_invalid <= w_spec_invalid;
            end

            // Adder overflow saturates to a correctly signed infinity
            if (w_capture) begin
                if (fadd_result[30:23] == 8'hFF) begin
                    r_result   <= {fadd_result[31], 8'hFF, 23'd0};
                    r_overflow <= 1'b1;
                end else begin
                    r_result   <= fadd_result;
                end
            end
        end
    end

    assign fadd_a   = r_a;
    assign fadd_b   = r_b;
    assign result   = r_result;
    assign invalid  = r_invalid;
    assign overflow = r_overflow;
    assign done     = (r_state == c_st_done);
    assign busy     = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_seq
// Brief    : Self-checking bench for fp_addsub_seq with a behavioural FP adder
//            attached and a cycle-level reference model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_seq;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [31:0] fadd_a, fadd_b, fadd_result, result;
    logic        done, busy, invalid, overflow;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;

    fp_addsub_seq #(.LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
        .op_a(op_a), .op_b(op_b), .fadd_a(fadd_a), .fadd_b(fadd_b),
        .fadd_result(fadd_result), .result(result), .done(done),
        .busy(busy), .invalid(invalid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Round-to-nearest-even single-precision adder, denormals flushed
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] big, sml;
        logic [27:0] mb, ms, m;
        logic        up;
        int          e, d;
        if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
        else begin big = y; sml = x; end
        if (big[30:23] == 8'hFF) return 32'h7FC00000;
        if (sml[30:23] == 8'h00) return (big[30:23] == 8'h00) ? 32'd0 : big;
        e  = int'(big[30:23]);
        d  = e - int'(sml[30:23]);
        mb = {2'b01, big[22:0], 3'b000};
        ms = {2'b01, sml[22:0], 3'b000};
        for (int i = 0; i < d && i < 30; i++) ms = (ms >> 1) | {27'd0, ms[0]};
        if (big[31] == sml[31]) begin
            m = mb + ms;
            if (m[27]) begin m = (m >> 1) | {27'd0, m[0]}; e++; end
        end else begin
            m = mb - ms;
            if (m == 28'd0) return 32'd0;
            while (m[26] == 1'b0) begin m = m << 1; e--; end
            if (e <= 0) return {big[31], 31'd0};
        end
        up = m[2] && (m[1] || m[0] || m[3]);
        m  = (m >> 3) + {27'd0, up};
        if (m[24]) begin m = m >> 1; e++; end
        if (e >= 255) return {big[31], 8'hFF, 23'd0};
        return {big[31], e[7:0], m[22:0]};
    endfunction

    always_comb fadd_result = fp_add(fadd_a, fadd_b);

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction
    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    // Outcome of one operation: final value, flags and done cycle
    task automatic model_op(input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic inv,
                            output logic ovf, output int lat);
        logic [31:0] s;
        inv = 1'b0; ovf = 1'b0; lat = 2; r = 32'd0;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[31] != b[31])) begin
            r = 32'h7FC00000; inv = 1'b1;
        end else if (is_inf(a))                 r = a;
        else if (is_inf(b))                     r = b;
        else if (is_zero(a) && is_zero(b))      r = {a[31] & b[31], 31'd0};
        else if (is_zero(a))                    r = b;
        else if (is_zero(b))                    r = a;
        else if (a[30:0] == b[30:0] && a[31] != b[31]) r = 32'd0;
        else begin
            lat = LATENCY + 2;
            s   = fp_add(a, b);
            if (s[30:23] == 8'hFF) begin r = {s[31], 8'hFF, 23'd0}; ovf = 1'b1; end
            else r = s;
        end
    endtask

    logic [31:0] m_res = 0, m_fa = 0, m_fb = 0, p_res = 0;
    logic        m_inv = 0, m_ovf = 0, p_inv = 0, p_ovf = 0;
    int          m_rem = 0;

    // m_rem: cycles of busy left; result published as the done cycle starts
    always @(posedge clk or negedge rst_n) begin : model
        logic [31:0] r, beff;
        logic        inv, ovf;
        int          lat;
        if (!rst_n) begin
            m_rem <= 0; m_res <= 0; m_fa <= 0; m_fb <= 0; m_inv <= 0; m_ovf <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin m_res <= p_res; m_inv <= p_inv; m_ovf <= p_ovf; end
        end else if (start) begin
            beff = {op_b[31] ^ op_sub, op_b[30:0]};
            model_op(op_a, beff, r, inv, ovf, lat);
            m_rem <= lat; m_fa <= op_a; m_fb <= beff;
            m_inv <= 1'b0; m_ovf <= 1'b0;
            p_res <= r; p_inv <= inv; p_ovf <= ovf;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("done", 32'(done), 32'(m_rem == 1));
        chk("result", result, m_res);
        chk("invalid", 32'(invalid), 32'(m_inv));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("fadd_a", fadd_a, m_fa);
        chk("fadd_b", fadd_b, m_fb);
        if (done) n_done++;
    end

    // One operation with hand-computed literal expectations
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_r,
                          input logic exp_inv, input logic exp_ovf, input int exp_cyc);
        int got;
        got = 0;
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b; op_sub = sub;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin got = c; break; end
        end
        chk({name, "_done_cycle"}, 32'(got), 32'(exp_cyc));
        chk({name, "_result"}, result, exp_r);
        chk({name, "_invalid"}, 32'(invalid), 32'(exp_inv));
        chk({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        run_op("add_1_2",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 4);
        run_op("sub_3_1",  32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 4);
        chk("sub_fadd_b", fadd_b, 32'hBF800000);
        run_op("sub_eq",   32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0, 2);
        chk("sub_eq_fadd_b", fadd_b, 32'hBFC00000);
        run_op("inf_ninf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0, 2);
        run_op("zero_pi",  32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 1'b0, 1'b0, 2);
        run_op("ovf",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 4);
        run_op("nan",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0, 2);
        run_op("fin_ninf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0, 2);
        run_op("nz_nz",    32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 2);
        run_op("denorm",   32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 2);
        run_op("neg_sum",  32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b0, 4);

        // Reset asserted while in EXEC aborts the operation
        @(posedge clk); #1;
        start = 1'b1; op_a = 32'h40A00000; op_b = 32'h40400000; op_sub = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("abort_result", result, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_fadd_a", fadd_a, 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);
        d0 = n_done;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        run_op("after_rst", 32'h40A00000, 32'h40400000, 1'b0, 32'h41000000, 1'b0, 1'b0, 4);

        // start held high across busy and DONE: exactly two accepted operations
        @(posedge clk); #1;
        d0 = n_done;
        start = 1'b1; op_a = 32'h3F800000; op_b = 32'h40000000; op_sub = 1'b0;
        @(posedge clk); #1 op_a = 32'h3F800000; op_b = 32'h3F800000;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("held_start_dones", 32'(n_done - d0), 32'd2);
        chk("held_start_result", result, 32'h40000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
